// File: rtl/inst_mem_loader.sv
// Instruction memory for the openmips fetch port, filled from a byte-serial boot stream while the core is held in reset.
// Optional macro INST_MEM_RANGE_CHK_EN: misaligned or out-of-range fetches return a NOP and set sticky fetch_err_o.
module inst_mem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_data_i,
    input  logic                  load_last_i,
    output logic                  load_ready_o,
    input  logic                  reload_i,
    output logic                  core_rst_o,
    output logic [ADDR_WIDTH:0]   loaded_words_o,
    output logic                  load_err_o,
    output logic                  fetch_err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [31:0]             mem [DEPTH];
    logic [1:0]              byte_cnt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [23:0]             asm_word;
    logic [ADDR_WIDTH:0]     loaded_words;
    logic                    load_err;
    logic                    core_rst;

    logic                    byte_accept;
    logic                    array_full;
    logic                    byte_store;
    logic                    word_done;
    logic                    reload_take;
    logic [31:0]             merged_word;
    logic [ADDR_WIDTH-1:0]   fetch_idx;
    logic                    fetch_bad;

    // Bytes fill from the top down; asm_word is zeroed between words, so a short final word is already padded.
    assign byte_accept = (state == ST_LOAD) && load_valid_i;
    assign array_full  = (loaded_words == FULL_COUNT);
    assign byte_store  = byte_accept && !array_full;
    assign word_done   = byte_store && ((byte_cnt == 2'd3) || load_last_i);
    assign reload_take = (state == ST_RUN) && reload_i;
    assign merged_word = {asm_word, 8'h00}
                       | ({24'd0, load_data_i} << {(2'd3 - byte_cnt), 3'b000});

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_next   = state;
        load_ready_o = 1'b0;
        case (state)
            ST_LOAD: begin
                load_ready_o = 1'b1;
                if (byte_accept && load_last_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reload_i) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt     <= 2'd0;
            ptr          <= '0;
            asm_word     <= 24'd0;
            loaded_words <= '0;
            load_err     <= 1'b0;
            core_rst     <= 1'b1;
        end else begin
            core_rst <= (state == ST_LOAD);
            if (reload_take) begin
                byte_cnt     <= 2'd0;
                ptr          <= '0;
                asm_word     <= 24'd0;
                loaded_words <= '0;
                load_err     <= 1'b0;
            end else if (byte_accept) begin
                if (array_full) begin
                    load_err <= 1'b1;
                end else if (word_done) begin
                    ptr          <= ptr + ADDR_WIDTH'(1);
                    loaded_words <= loaded_words + (ADDR_WIDTH + 1)'(1);
                    byte_cnt     <= 2'd0;
                    asm_word     <= 24'd0;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                    asm_word <= merged_word[31:8];
                end
            end
        end
    end

    // NOTE: the word array has no reset; a boot image survives rst and a RAM macro stays inferable.
    always_ff @(posedge clk) begin
        if (word_done) begin
            mem[ptr] <= merged_word;
        end
    end

    assign fetch_idx = rom_addr_i[ADDR_WIDTH+1:2];

`ifdef INST_MEM_RANGE_CHK_EN
    assign fetch_bad = (rom_addr_i[1:0] != 2'b00) || (|rom_addr_i[31:ADDR_WIDTH+2]);

    logic fetch_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if ((state == ST_RUN) && rom_ce_i && fetch_bad) begin
            fetch_err <= 1'b1;
        end
    end

    assign fetch_err_o = fetch_err;
`else
    // Without range checking the byte offset and upper address bits alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};
    assign fetch_bad        = 1'b0;
    assign fetch_err_o      = 1'b0;
`endif

    // Combinational read: the core's IF/ID register captures it at the following edge.
    always_comb begin
        rom_data_o = 32'h0000_0000;
        if ((state == ST_RUN) && rom_ce_i && !fetch_bad) begin
            rom_data_o = mem[fetch_idx];
        end
    end

    assign core_rst_o     = core_rst;
    assign loaded_words_o = loaded_words;
    assign load_err_o     = load_err;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed boot images plus random loads against an array-level image model.
module tb_inst_mem_loader;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          rom_ce_i;
    logic [31:0]   rom_addr_i;
    logic [31:0]   rom_data_o;
    logic          load_valid_i;
    logic [7:0]    load_data_i;
    logic          load_last_i;
    logic          load_ready_o;
    logic          reload_i;
    logic          core_rst_o;
    logic [AW:0]   loaded_words_o;
    logic          load_err_o;
    logic          fetch_err_o;

    inst_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce_i       (rom_ce_i),
        .rom_addr_i     (rom_addr_i),
        .rom_data_o     (rom_data_o),
        .load_valid_i   (load_valid_i),
        .load_data_i    (load_data_i),
        .load_last_i    (load_last_i),
        .load_ready_o   (load_ready_o),
        .reload_i       (reload_i),
        .core_rst_o     (core_rst_o),
        .loaded_words_o (loaded_words_o),
        .load_err_o     (load_err_o),
        .fetch_err_o    (fetch_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference image: what the array should hold, derived from the byte stream alone.
    logic [31:0] ref_mem [DEPTH];
    int          ref_loaded;
    bit          ref_err;
    logic [7:0]  stream [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input bit aborted);
        int n;
        int words;
        logic [31:0] w;
        n     = stream.size();
        words = aborted ? n / 4 : (n + 3) / 4;
        if (words > DEPTH) words = DEPTH;
        for (int k = 0; k < words; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n) w[31-8*j -: 8] = stream[4*k+j];
            end
            ref_mem[k] = w;
        end
        ref_loaded = aborted ? 0 : words;
        ref_err    = !aborted && (n > 4 * DEPTH);
    endtask

    function automatic logic [31:0] exp_fetch(input logic ce, input logic [31:0] addr);
        logic [AW-1:0] idx;
        idx = addr[AW+1:2];
        if (!ce) return 32'h0;
`ifdef INST_MEM_RANGE_CHK_EN
        if (addr[1:0] != 2'b00 || (addr >> (AW + 2)) != 0) return 32'h0;
`endif
        return ref_mem[idx];
    endfunction

    // Sends the queued stream; an aborted load never raises load_last_i. Returns at the negedge after the final accept.
    task automatic send_stream(input int max_gap, input int count, input bit aborted);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge clk);
                load_valid_i = 1'b0;
                load_last_i  = 1'($urandom);
                load_data_i  = 8'($urandom);
            end
            @(negedge clk);
            load_valid_i = 1'b1;
            load_data_i  = stream[i];
            load_last_i  = !aborted && (i == count - 1);
            #1 check("ready_in_load", 32'(load_ready_o), 32'd1);
        end
        @(negedge clk);
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        model_apply(1'b0);
        check({tag, "_ready_run"}, 32'(load_ready_o), 32'd0);
        check({tag, "_core_rst_hold"}, 32'(core_rst_o), 32'd1);
        check({tag, "_loaded"}, 32'(loaded_words_o), 32'(ref_loaded));
        check({tag, "_load_err"}, 32'(load_err_o), 32'(ref_err));
        @(negedge clk);
        check({tag, "_core_rst_fall"}, 32'(core_rst_o), 32'd0);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload_i = 1'b1;
        @(negedge clk);
        check("reload_ready", 32'(load_ready_o), 32'd1);
        check("reload_loaded", 32'(loaded_words_o), 32'd0);
        check("reload_err", 32'(load_err_o), 32'd0);
        check("reload_core_rst_lag", 32'(core_rst_o), 32'd0);
        @(negedge clk);
        reload_i = 1'b0;
        check("reload_core_rst", 32'(core_rst_o), 32'd1);
    endtask

    task automatic fetch_check(input string tag, input logic ce, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        #1 check(tag, rom_data_o, exp);
    endtask

    task automatic fetch_all(input string tag);
        for (int k = 0; k < DEPTH; k++) fetch_check(tag, 1'b1, 32'(k * 4), ref_mem[k]);
    endtask

    task automatic load_basic(input int max_gap);
        stream = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
        send_stream(max_gap, stream.size(), 1'b0);
        finish_load("basic");
        check("basic_loaded_lit", 32'(loaded_words_o), 32'd2);
        fetch_check("basic_w0", 1'b1, 32'h0, 32'h3401_1100);
        fetch_check("basic_w1", 1'b1, 32'h4, 32'h3402_0020);
        fetch_check("basic_ce0", 1'b0, 32'h4, 32'h0);
    endtask

    initial begin
        logic [31:0] addr;
        logic        ce;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        rom_ce_i     = 1'b1;
        rom_addr_i   = 32'h0;
        load_valid_i = 1'b0;
        load_data_i  = 8'h00;
        load_last_i  = 1'b0;
        reload_i     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_core_rst", 32'(core_rst_o), 32'd1);
        check("rst_ready", 32'(load_ready_o), 32'd1);
        check("rst_loaded", 32'(loaded_words_o), 32'd0);
        check("rst_load_err", 32'(load_err_o), 32'd0);
        check("rst_fetch_err", 32'(fetch_err_o), 32'd0);
        check("rst_rom_data", rom_data_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("load_fetch_zero", rom_data_o, 32'h0);

        load_basic(0);

        do_reload();
        stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        send_stream(0, stream.size(), 1'b0);
        finish_load("partial");
        fetch_check("partial_w0", 1'b1, 32'h0, 32'hAABB_CCDD);
        fetch_check("partial_w1", 1'b1, 32'h4, 32'hEEFF_0000);

        do_reload();
        load_basic(3);
        repeat (4) begin
            @(negedge clk);
            check("ready_stays_low", 32'(load_ready_o), 32'd0);
        end

        do_reload();
        stream.delete();
        repeat (4 * DEPTH) stream.push_back(8'($urandom));
        send_stream(1, stream.size(), 1'b0);
        finish_load("exact_fill");
        fetch_all("exact_fill_rd");

        do_reload();
        stream.delete();
        repeat (4 * DEPTH + 1) stream.push_back(8'($urandom));
        send_stream(1, stream.size(), 1'b0);
        finish_load("overflow");
        check("overflow_err_lit", 32'(load_err_o), 32'd1);
        fetch_all("overflow_rd");

        // Reset mid-load: the first completed word is overwritten, the rest of the array keeps the old image.
        do_reload();
        stream.delete();
        repeat (5) stream.push_back(8'($urandom));
        send_stream(0, 5, 1'b1);
        model_apply(1'b1);
        rst = 1'b1;
        #1;
        check("midrst_core_rst", 32'(core_rst_o), 32'd1);
        check("midrst_ready", 32'(load_ready_o), 32'd1);
        check("midrst_loaded", 32'(loaded_words_o), 32'd0);
        check("midrst_rom_data", rom_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stream.delete();
        repeat (4) stream.push_back(8'($urandom));
        send_stream(0, stream.size(), 1'b0);
        finish_load("after_rst");
        fetch_all("retained_rd");

        for (int it = 0; it < 6; it++) begin
            do_reload();
            stream.delete();
            repeat ($urandom_range(1, 4 * DEPTH + 4)) stream.push_back(8'($urandom));
            send_stream(2, stream.size(), 1'b0);
            finish_load("rand");
            repeat (10) begin
                ce   = 1'($urandom);
                addr = $urandom;
`ifdef INST_MEM_RANGE_CHK_EN
                addr = addr & 32'((DEPTH - 1) * 4);
`endif
                fetch_check("rand_fetch", ce, addr, exp_fetch(ce, addr));
            end
        end

        // Out-of-range and misaligned fetches: NOP with checking, aliasing without.
        addr = 32'(1) << (AW + 2);
        fetch_check("range_hi", 1'b1, addr, exp_fetch(1'b1, addr));
        fetch_check("range_misalign", 1'b1, 32'h5, exp_fetch(1'b1, 32'h5));
        @(negedge clk);
        rom_ce_i = 1'b0;
`ifdef INST_MEM_RANGE_CHK_EN
        check("fetch_err_set", 32'(fetch_err_o), 32'd1);
`else
        check("fetch_err_tied", 32'(fetch_err_o), 32'd0);
`endif
        check("range_alias_w0", ref_mem[0], exp_fetch(1'b1, addr));
        do_reload();
        load_basic(0);
`ifdef INST_MEM_RANGE_CHK_EN
        check("fetch_err_sticky", 32'(fetch_err_o), 32'd1);
`else
        check("fetch_err_still0", 32'(fetch_err_o), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
